// File: rtl/led_drv_pkg.sv
// Shared types for the LED shift-register driver.
// State encoding and width helper used by the top and its divider.
package led_drv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/led_clk_tick.sv
// Shift-clock divider: one-cycle tick after CLK_DIV enabled cycles.
// Restart re-aligns the count to each new FSM state.
module led_clk_tick
    import led_drv_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int CW = clog2_min1(CLK_DIV);
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (restart || !en)
            cnt <= '0;
        else if (cnt != TERM)
            cnt <= cnt + 1'b1;
    end

    assign tick = en && (cnt == TERM);

endmodule

// File: rtl/led_shift_driver.sv
// Serial driver for cascaded 595-style LED boards.
// Shifts one handshaked frame out on a divided clock, then strobes the latch.
module led_shift_driver
    import led_drv_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int CLK_DIV    = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit SWAP_BYTES = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_sclk,
    output logic              o_sdata,
    output logic              o_latch,
    output logic              o_busy,
    output logic              o_done
);

    localparam int H  = DATA_W / 2;
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_W);

    state_t            state, state_n;
    logic [DATA_W-1:0] sreg, sreg_n, frame_in;
    logic [BW-1:0]     bits, bits_n;
    logic              tick;
    logic              sclk_n, sdata_n, latch_n, done_n;

    led_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (i_clk),
        .rst     (i_rst),
        .en      (state != IDLE),
        .restart (state_n != state),
        .tick    (tick)
    );

    assign frame_in = SWAP_BYTES ? {i_data[H-1:0], i_data[DATA_W-1:H]}
                                 : i_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            sreg    <= '0;
            bits    <= '0;
            o_sclk  <= 1'b0;
            o_sdata <= 1'b0;
            o_latch <= 1'b1;
            o_done  <= 1'b0;
        end else begin
            state   <= state_n;
            sreg    <= sreg_n;
            bits    <= bits_n;
            o_sclk  <= sclk_n;
            o_sdata <= sdata_n;
            o_latch <= latch_n;
            o_done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     if (i_valid) state_n = SHIFT_LO;
            SHIFT_LO: if (tick) state_n = SHIFT_HI;
            SHIFT_HI: if (tick) state_n = (bits == LAST) ? LATCH : SHIFT_LO;
            LATCH:    if (tick) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // bits counts rising shift-clock edges issued for the current frame
    always_comb begin
        sreg_n = sreg;
        bits_n = bits;
        if (state == IDLE && i_valid) begin
            sreg_n = frame_in;
            bits_n = '0;
        end else if (state == SHIFT_LO && tick) begin
            bits_n = bits + 1'b1;
        end else if (state == SHIFT_HI && tick) begin
            if (bits == LAST)
                bits_n = '0;
            else if (MSB_FIRST)
                sreg_n = {sreg[DATA_W-2:0], 1'b0};
            else
                sreg_n = {1'b0, sreg[DATA_W-1:1]};
        end
    end

    always_comb begin
        sclk_n  = (state_n == SHIFT_HI);
        sdata_n = 1'b0;
        if (state_n == SHIFT_LO || state_n == SHIFT_HI)
            sdata_n = MSB_FIRST ? sreg_n[DATA_W-1] : sreg_n[0];
        latch_n = (state_n != LATCH);
        done_n  = (state == LATCH) && (state_n == IDLE);
    end

    assign o_ready = (state == IDLE);
    assign o_busy  = ~o_ready;

endmodule

// File: tb/tb_led_shift_driver.sv
// Self-checking bench for led_shift_driver.
// Three instances cover default, LSB-first/no-swap, and fast 32-bit configs.
module tb_led_shift_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_a, data_b;
    logic [31:0] data_c;
    logic [2:0]  valid_v, ready_v, sclk_v, sdata_v, latch_v, busy_v, done_v;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    bit   bits_q[3][$];
    int   rise_q[3][$];
    int   done_q[3][$];
    int   latch_low[3];
    int   sdata_viol[3];
    logic prev_sclk[3];
    logic prev_sdata[3];
    bit   exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led_shift_driver dut_a (
        .i_clk(clk), .i_rst(rst), .i_data(data_a), .i_valid(valid_v[0]),
        .o_ready(ready_v[0]), .o_sclk(sclk_v[0]), .o_sdata(sdata_v[0]),
        .o_latch(latch_v[0]), .o_busy(busy_v[0]), .o_done(done_v[0])
    );

    led_shift_driver #(.MSB_FIRST(1'b0), .SWAP_BYTES(1'b0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_data(data_b), .i_valid(valid_v[1]),
        .o_ready(ready_v[1]), .o_sclk(sclk_v[1]), .o_sdata(sdata_v[1]),
        .o_latch(latch_v[1]), .o_busy(busy_v[1]), .o_done(done_v[1])
    );

    led_shift_driver #(.DATA_W(32), .CLK_DIV(1)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_data(data_c), .i_valid(valid_v[2]),
        .o_ready(ready_v[2]), .o_sclk(sclk_v[2]), .o_sdata(sdata_v[2]),
        .o_latch(latch_v[2]), .o_busy(busy_v[2]), .o_done(done_v[2])
    );

    // Board-side observer: what a 595 chain would see on its pins
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (sclk_v[k] === 1'b1 && prev_sclk[k] === 1'b0) begin
                bits_q[k].push_back(sdata_v[k]);
                rise_q[k].push_back(cyc);
            end
            if (sclk_v[k] === 1'b1 && prev_sclk[k] === 1'b1 &&
                sdata_v[k] !== prev_sdata[k])
                sdata_viol[k]++;
            if (latch_v[k] === 1'b0) latch_low[k]++;
            if (done_v[k] === 1'b1) done_q[k].push_back(cyc);
            prev_sclk[k]  = sclk_v[k];
            prev_sdata[k] = sdata_v[k];
        end
    end

    task automatic clear_mon(input int k);
        bits_q[k].delete();
        rise_q[k].delete();
        done_q[k].delete();
        latch_low[k] = 0;
    endtask

    // Reference: the sequence of bits a board samples for one frame
    function automatic void build_exp(input logic [31:0] d, input int w,
                                      input bit msb, input bit swp);
        logic [31:0] f;
        logic [31:0] mask;
        int h;
        h = w / 2;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
        f = d & mask;
        if (swp)
            f = (((f & ((32'd1 << h) - 1)) << h) | (f >> h)) & mask;
        for (int i = 0; i < w; i++)
            exp_q.push_back(msb ? f[w-1-i] : f[i]);
    endfunction

    function automatic int bit_errs(input int k);
        int e;
        e = 0;
        if (bits_q[k].size() != exp_q.size())
            return 1000 + bits_q[k].size();
        for (int i = 0; i < exp_q.size(); i++)
            if (bits_q[k][i] != exp_q[i]) e++;
        return e;
    endfunction

    task automatic set_data(input int k, input logic [31:0] d);
        case (k)
            0: data_a = d[15:0];
            1: data_b = d[15:0];
            default: data_c = d;
        endcase
    endtask

    task automatic send(input int k, input logic [31:0] d, input bit hold,
                        output int acc);
        @(negedge clk);
        set_data(k, d);
        valid_v[k] = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) valid_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (done_q[k].size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_done dut%0d: got %0d done pulses, need %0d",
                     k, done_q[k].size(), n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        valid_v = '0;
        data_a = '0;
        data_b = '0;
        data_c = '0;
        #1;
        checks++;
        if (sclk_v !== 3'b000) begin
            failures++;
            $display("FAIL reset_sclk: got %b need 000", sclk_v);
        end
        checks++;
        if (sdata_v !== 3'b000) begin
            failures++;
            $display("FAIL reset_sdata: got %b need 000", sdata_v);
        end
        checks++;
        if (latch_v !== 3'b111) begin
            failures++;
            $display("FAIL reset_latch: got %b need 111", latch_v);
        end
        checks++;
        if (ready_v !== 3'b111 || busy_v !== 3'b000) begin
            failures++;
            $display("FAIL reset_ready: ready %b busy %b need 111/000",
                     ready_v, busy_v);
        end
        checks++;
        if (done_v !== 3'b000) begin
            failures++;
            $display("FAIL reset_done: got %b need 000", done_v);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_default_frame;
        logic [15:0] pat;
        int acc;
        bit ok;
        int e;
        pat = 16'b1100_0011_1010_0101;
        clear_mon(0);
        send(0, 32'h0000_A5C3, 1'b0, acc);
        wait_done(0, 1, ok);
        repeat (10) @(negedge clk);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(pat[15-i]);
        e = bit_errs(0);
        checks++;
        if (e !== 0) begin
            failures++;
            $display("FAIL a5c3_bits: %0d bit errors, %0d bits seen",
                     e, bits_q[0].size());
        end
        checks++;
        if (latch_low[0] !== 4) begin
            failures++;
            $display("FAIL a5c3_latch: low %0d cycles need 4", latch_low[0]);
        end
        checks++;
        if (done_q[0].size() !== 1) begin
            failures++;
            $display("FAIL a5c3_done_count: got %0d need 1", done_q[0].size());
        end else begin
            checks++;
            if (done_q[0][0] - acc !== 132) begin
                failures++;
                $display("FAIL a5c3_latency: got %0d need 132",
                         done_q[0][0] - acc);
            end
        end
    endtask

    task automatic test_random(input int k);
        logic [31:0] d;
        int acc;
        bit ok;
        int e;
        for (int n = 0; n < 4; n++) begin
            d = $urandom & 32'hFFFF;
            clear_mon(k);
            send(k, d, 1'b0, acc);
            wait_done(k, 1, ok);
            exp_q.delete();
            if (k == 0) build_exp(d, 16, 1'b1, 1'b1);
            else        build_exp(d, 16, 1'b0, 1'b0);
            e = bit_errs(k);
            checks++;
            if (e !== 0) begin
                failures++;
                $display("FAIL random_bits dut%0d data %h: %0d errors", k, d, e);
            end
        end
    endtask

    task automatic test_lsb_first;
        int acc;
        bit ok;
        int e;
        clear_mon(1);
        send(1, 32'h0000_0001, 1'b0, acc);
        wait_done(1, 1, ok);
        exp_q.delete();
        exp_q.push_back(1'b1);
        for (int i = 1; i < 16; i++) exp_q.push_back(1'b0);
        e = bit_errs(1);
        checks++;
        if (e !== 0) begin
            failures++;
            $display("FAIL lsb_first_0001: %0d bit errors", e);
        end
        checks++;
        if (done_q[1].size() > 0 && done_q[1][0] - acc !== 132) begin
            failures++;
            $display("FAIL lsb_latency: got %0d need 132", done_q[1][0] - acc);
        end
    endtask

    task automatic test_busy_ignore;
        int acc;
        int rviol;
        bit ok;
        int e;
        rviol = 0;
        clear_mon(0);
        send(0, 32'h0000_FFFF, 1'b1, acc);
        data_a = 16'h0000;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            if (done_v[0] === 1'b1) break;
            if (ready_v[0] !== 1'b0) rviol++;
        end
        checks++;
        if (rviol !== 0) begin
            failures++;
            $display("FAIL busy_ready: ready high %0d busy cycles need 0", rviol);
        end
        checks++;
        if (ready_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL done_ready: got %b need 1", ready_v[0]);
        end
        @(posedge clk);
        #1;
        valid_v[0] = 1'b0;
        wait_done(0, 2, ok);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(1'b1);
        for (int i = 0; i < 16; i++) exp_q.push_back(1'b0);
        e = bit_errs(0);
        checks++;
        if (e !== 0) begin
            failures++;
            $display("FAIL busy_bits: %0d bit errors, %0d bits seen",
                     e, bits_q[0].size());
        end
        checks++;
        if (done_q[0].size() >= 2 && done_q[0][1] - done_q[0][0] !== 133) begin
            failures++;
            $display("FAIL busy_b2b_gap: got %0d need 133",
                     done_q[0][1] - done_q[0][0]);
        end
    endtask

    task automatic test_reset_midframe;
        int acc;
        bit ok;
        int e;
        clear_mon(0);
        send(0, $urandom & 32'hFFFF, 1'b0, acc);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #1;
            if (bits_q[0].size() >= 7) break;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (sclk_v[0] !== 1'b0 || sdata_v[0] !== 1'b0 || latch_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL abort_pins: sclk %b sdata %b latch %b need 0 0 1",
                     sclk_v[0], sdata_v[0], latch_v[0]);
        end
        checks++;
        if (ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL abort_ready: ready %b busy %b need 1 0",
                     ready_v[0], busy_v[0]);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (latch_low[0] !== 0 || done_q[0].size() !== 0) begin
            failures++;
            $display("FAIL abort_latch: latch low %0d done %0d need 0 0",
                     latch_low[0], done_q[0].size());
        end
        clear_mon(0);
        send(0, 32'h0000_00FF, 1'b0, acc);
        wait_done(0, 1, ok);
        exp_q.delete();
        build_exp(32'h0000_00FF, 16, 1'b1, 1'b1);
        e = bit_errs(0);
        checks++;
        if (e !== 0) begin
            failures++;
            $display("FAIL after_abort_bits: %0d bit errors", e);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d1, d2;
        int acc;
        int perr;
        bit ok;
        int e;
        d1 = $urandom;
        d2 = $urandom;
        perr = 0;
        clear_mon(2);
        send(2, d1, 1'b1, acc);
        data_c = d2;
        wait_done(2, 1, ok);
        @(posedge clk);
        #1;
        valid_v[2] = 1'b0;
        wait_done(2, 2, ok);
        exp_q.delete();
        build_exp(d1, 32, 1'b1, 1'b1);
        build_exp(d2, 32, 1'b1, 1'b1);
        e = bit_errs(2);
        checks++;
        if (e !== 0) begin
            failures++;
            $display("FAIL b2b_bits: %0d bit errors, %0d bits seen",
                     e, bits_q[2].size());
        end
        if (done_q[2].size() >= 2 && rise_q[2].size() == 64) begin
            checks++;
            if (done_q[2][0] - acc !== 65 || done_q[2][1] - done_q[2][0] !== 66) begin
                failures++;
                $display("FAIL b2b_frame: first %0d gap %0d need 65 66",
                         done_q[2][0] - acc, done_q[2][1] - done_q[2][0]);
            end
            for (int i = 1; i < 64; i++)
                if (i != 32 && rise_q[2][i] - rise_q[2][i-1] != 2) perr++;
            checks++;
            if (perr !== 0) begin
                failures++;
                $display("FAIL b2b_sclk_period: %0d periods not 2", perr);
            end
            checks++;
            if (rise_q[2][0] !== acc + 1 || rise_q[2][32] !== done_q[2][0] + 2) begin
                failures++;
                $display("FAIL b2b_first_bit: rises %0d %0d need %0d %0d",
                         rise_q[2][0], rise_q[2][32], acc + 1, done_q[2][0] + 2);
            end
        end else begin
            checks++;
            failures++;
            $display("FAIL b2b_counts: done %0d rises %0d need 2 64",
                     done_q[2].size(), rise_q[2].size());
        end
    endtask

    task automatic test_sdata_stable;
        checks++;
        if (sdata_viol[0] + sdata_viol[1] + sdata_viol[2] !== 0) begin
            failures++;
            $display("FAIL sdata_stable: %0d/%0d/%0d changes while sclk high",
                     sdata_viol[0], sdata_viol[1], sdata_viol[2]);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            latch_low[k]  = 0;
            sdata_viol[k] = 0;
            prev_sclk[k]  = 1'b0;
            prev_sdata[k] = 1'b0;
        end
        test_reset;
        test_default_frame;
        test_random(0);
        test_lsb_first;
        test_random(1);
        test_busy_ignore;
        test_reset_midframe;
        test_back_to_back;
        test_sdata_stable;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
